// File: rtl/au_pkg.sv
// Shared arithmetic-unit definitions: FSM state encoding and default width.
// Imported by the serial adder and the combinational adder/subtractor.
package au_pkg;

    localparam int AU_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } au_state_t;

endpackage

// File: rtl/full_adder_1bit.sv
// Single full-adder cell built from gate primitives.
// The serial adder reuses this one cell for every bit position.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ab_x;
    logic ab_a;
    logic c_a;

    xor g_x0 (ab_x, a, b);
    xor g_x1 (s, ab_x, cin);
    and g_a0 (ab_a, a, b);
    and g_a1 (c_a, ab_x, cin);
    or  g_o0 (cout, ab_a, c_a);

endmodule

// File: rtl/serial_adder_4bit.sv
// Bit-serial adder: S = A + B + cin, one bit per cycle, LSB first.
// start/busy/done handshake; S/cout update only on the completion edge.
module serial_adder_4bit
    import au_pkg::*;
#(
    parameter int WIDTH = AU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    au_state_t        state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             carry;
    logic [CW-1:0]    count;

    logic             fa_s;
    logic             fa_co;
    logic             last;
    logic [WIDTH-1:0] r_next;

    full_adder_1bit u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_co)
    );

    assign last   = (count == CW'(WIDTH - 1));
    assign r_next = {fa_s, r_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            S     <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        carry <= cin;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    r_sh  <= r_next;
                    carry <= fa_co;
                    count <= count + 1'b1;
                    // final bit comes straight from the cell, not r_sh
                    if (last) begin
                        S     <= r_next;
                        cout  <= fa_co;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_4bit.sv
// Directed bench for serial_adder_4bit: vector table plus
// handshake corner sequences (ignored start, reset mid-run, back-to-back).
module tb_serial_adder_4bit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       cin;
    logic       busy;
    logic       done;
    logic [3:0] S;
    logic       cout;

    int checks;
    int errors;
    logic [3:0] exp_hold;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic [3:0] s;
        logic       co;
    } vec_t;

    vec_t vecs[8];

    serial_adder_4bit #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Drive operands with start at a negedge; return at the negedge after acceptance.
    task automatic launch(input logic [3:0] a, input logic [3:0] b, input logic c);
        @(negedge clk);
        A     = a;
        B     = b;
        cin   = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Step negedges until done, counting busy cycles and any premature S change.
    task automatic wait_done(output int n, output int bcnt, output int bad_s);
        n     = 0;
        bcnt  = 0;
        bad_s = 0;
        while (!done && n < 20) begin
            if (busy) bcnt++;
            if (S !== exp_hold) bad_s++;
            @(negedge clk);
            n++;
        end
    endtask

    int n;
    int bc;
    int bs;
    int dcnt;

    initial begin
        checks   = 0;
        errors   = 0;
        exp_hold = 4'd0;
        rst_n    = 1'b0;
        start    = 1'b0;
        A        = '0;
        B        = '0;
        cin      = 1'b0;

        vecs[0] = '{4'd5,  4'd3,  1'b0, 4'd8,  1'b0};
        vecs[1] = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1};
        vecs[2] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
        vecs[3] = '{4'd3,  4'd10, 1'b1, 4'd14, 1'b0};
        vecs[4] = '{4'd7,  4'd13, 1'b1, 4'd5,  1'b1};
        vecs[5] = '{4'd2,  4'd2,  1'b0, 4'd4,  1'b0};
        vecs[6] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0};
        vecs[7] = '{4'd9,  4'd6,  1'b0, 4'd15, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_s", int'(S), 0);
        chk("rst_cout", int'(cout), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        for (int i = 0; i < 8; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].ci);
            wait_done(n, bc, bs);
            chk($sformatf("v%0d_latency", i), n, 4);
            chk($sformatf("v%0d_busy_cycles", i), bc, 4);
            chk($sformatf("v%0d_s_hold", i), bs, 0);
            chk($sformatf("v%0d_s", i), int'(S), int'(vecs[i].s));
            chk($sformatf("v%0d_cout", i), int'(cout), int'(vecs[i].co));
            exp_hold = vecs[i].s;
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), int'(done), 0);
            chk($sformatf("v%0d_idle_busy", i), int'(busy), 0);
        end

        // start re-pulsed during RUN must be ignored
        launch(4'd5, 4'd3, 1'b0);
        A     = 4'd1;
        B     = 4'd1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        dcnt  = 0;
        for (int k = 0; k < 10; k++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        chk("ign_done_count", dcnt, 1);
        chk("ign_s", int'(S), 8);
        chk("ign_cout", int'(cout), 0);
        exp_hold = 4'd8;

        // reset asserted during the second RUN cycle
        launch(4'd5, 4'd3, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_s", int'(S), 0);
        chk("mid_rst_cout", int'(cout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt  = 0;
        for (int k = 0; k < 8; k++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        chk("mid_rst_no_done", dcnt, 0);
        exp_hold = 4'd0;
        launch(4'd2, 4'd2, 1'b0);
        wait_done(n, bc, bs);
        chk("post_rst_latency", n, 4);
        chk("post_rst_s", int'(S), 4);
        exp_hold = 4'd4;
        @(negedge clk);

        // back-to-back: new start accepted from DONE
        launch(4'd1, 4'd2, 1'b0);
        wait_done(n, bc, bs);
        chk("b2b_first_s", int'(S), 3);
        chk("b2b_first_done", int'(done), 1);
        exp_hold = 4'd3;
        A     = 4'd9;
        B     = 4'd6;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_rerun_busy", int'(busy), 1);
        chk("b2b_rerun_done", int'(done), 0);
        wait_done(n, bc, bs);
        chk("b2b_gap", n + 1, 5);
        chk("b2b_s_hold", bs, 0);
        chk("b2b_s", int'(S), 15);
        chk("b2b_cout", int'(cout), 0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
